fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit Harvard core. Sits directly upstream of the decode/register-file read.
- Owns the program counter and drives the address input of the combinational instruction memory.
- Captures the returned 32-bit word into an IF/ID pipeline register for decode.
- Supports stall, branch/jump redirect with flush, and a HALT opcode that freezes fetch.

Parameters:
- PC_W, 6, program counter / instruction-memory address width (64 words)
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush or reset
- HALT_OP, 6'h3F, opcode in instr[31:26] that halts fetch

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- imem_addr  out  PC_W  address to instruction memory; equals the PC register
- imem_data  in  INSTR_W  instruction word returned combinationally for imem_addr
- stall  in  1  hold request from downstream (hazard unit)
- redirect_valid  in  1  branch/jump taken; load redirect_target
- redirect_target  in  PC_W  new PC
- if_id_instr  out  INSTR_W  registered instruction to decode
- if_id_pc  out  PC_W  address of if_id_instr
- if_id_pc_plus1  out  PC_W  if_id_pc+1, modulo 2^PC_W
- if_id_valid  out  1  if_id_instr is a real fetched instruction
- halted  out  1  fetch frozen by HALT

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0.
  - State=RUN, halted=0.
  - Reset mid-operation discards everything in flight.
  - First capture happens on the first rising edge after rst rises.
- imem_addr = pc (register output, no logic). Fetch-to-IF/ID latency is 1 cycle.
- State RUN, per rising edge, in priority order:
  1. redirect_valid=1: pc<=redirect_target; if_id_valid<=0; if_id_instr<=NOP_INSTR; if_id_pc and if_id_pc_plus1 hold. Redirect overrides stall and any HALT in the current fetch word.
  2. stall=1: pc and all if_id_* hold their values.
  3. imem_data[31:26]==HALT_OP: if_id_instr<=imem_data, if_id_pc<=pc, if_id_pc_plus1<=pc+1, if_id_valid<=1; pc holds; state<=HALTED.
  4. Otherwise: if_id_instr<=imem_data, if_id_pc<=pc, if_id_pc_plus1<=pc+1, if_id_valid<=1, pc<=pc+1.
- State HALTED:
  - halted=1, registered: rises the cycle the HALT instruction appears in IF/ID.
  - redirect_valid=1: pc<=redirect_target, if_id_valid<=0, state<=RUN, halted<=0. This covers an older branch resolving after a speculative HALT.
  - stall=1 without redirect: all registers hold.
  - Otherwise: pc holds; if_id_valid<=0; if_id_instr<=NOP_INSTR.
- Width/wrap:
  - pc+1 is computed modulo 2^PC_W (63->0), including if_id_pc_plus1.
  - No overflow flag.
  - redirect_target is used unmodified.
- Simultaneous redirect and stall: redirect wins, and the flush bubble is inserted even though stall is high.
- Two back-to-back redirects: the second target wins; if_id_valid stays 0 for both cycles.
- Only two states, RUN and HALTED. An unreachable encoding recovers to RUN.

Test Plan:
- Reset then sequential run: rst low 2 cycles, release, imem returns word k = 32'h0000_1000+k → imem_addr 0,1,2,3 on successive cycles. IF/ID shows pc 0,1,2 with matching words, valid=1 from the first edge. All outputs are 0 during reset.
- Stall: at pc=5 assert stall 3 cycles → imem_addr stays 5 and if_id_pc stays 4 for 3 cycles. On release, if_id_pc=5 and pc=6.
- Redirect with simultaneous stall: at pc=10 drive redirect_valid=1, target=40, stall=1 → next cycle imem_addr=40, if_id_valid=0, if_id_instr=0. The following cycle if_id_pc=40 with valid=1.
- Wrap: redirect to 62 → fetch 62, 63, 0. if_id_pc_plus1 for pc 63 equals 0.
- HALT: word at addr 7 = 32'hFC00_0000 → if_id_pc=7 with valid=1 and halted=1 the next cycle. pc stays 7; the following cycles show valid=0. Then redirect target=20 → halted=0, fetch resumes at 20.
- Async reset mid-run: drop rst between edges at pc=30 → pc=0, valid=0, halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID register for decode.
//
// state     | meaning
// ----------|----------------------------------------------------------
// ST_RUN    | fetching: redirect > stall > HALT capture > sequential
// ST_HALTED | HALT captured; fetch frozen until a redirect arrives
module fetch_stage #(
    parameter int                   PC_W      = 6,
    parameter int                   INSTR_W   = 32,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
    parameter logic [5:0]           HALT_OP   = 6'h3F
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]   imem_data,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_target,
    output logic [INSTR_W-1:0]   if_id_instr,
    output logic [PC_W-1:0]      if_id_pc,
    output logic [PC_W-1:0]      if_id_pc_plus1,
    output logic                 if_id_valid,
    output logic                 halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      ifpc_q, ifpc_d;
    logic [PC_W-1:0]      ifpc1_q, ifpc1_d;
    logic                 valid_q, valid_d;
    logic [PC_W-1:0]      pc_plus1;
    logic                 is_halt;

    // Natural PC_W-bit wrap gives the 63 -> 0 rollover.
    assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign is_halt  = (imem_data[INSTR_W-1 -: 6] == HALT_OP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifpc1_d = ifpc1_q;
        valid_d = valid_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (!stall) begin
                    instr_d = imem_data;
                    ifpc_d  = pc_q;
                    ifpc1_d = pc_plus1;
                    valid_d = 1'b1;
                    if (is_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = ST_RUN;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifpc_q  <= '0;
            ifpc1_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc1_q <= ifpc1_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = ifpc_q;
    assign if_id_pc_plus1 = ifpc1_q;
    assign if_id_valid    = valid_q;
    assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: per-cycle vectors with hand-derived
// expected outputs, queued when driven and compared after the clock edge.
module tb_fetch_stage;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [5:0]  rt;
        logic [5:0]  addr;
        logic [31:0] instr;
        logic [5:0]  pc;
        logic [5:0]  pc1;
        logic        valid;
        logic        halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [5:0]  redirect_target;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_pc;
    logic [5:0]  if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;

    logic [31:0] mem [64];
    vec_t        tbl[$];
    vec_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus1  (if_id_pc_plus1),
        .if_id_valid     (if_id_valid),
        .halted          (halted)
    );

    function automatic vec_t mk(input logic r, input logic s, input logic rv, input int rt,
                                input int addr, input logic [31:0] instr, input int pc,
                                input int pc1, input logic v, input logic h);
        vec_t t;
        t.rst = r; t.stall = s; t.rv = rv; t.rt = 6'(rt);
        t.addr = 6'(addr); t.instr = instr; t.pc = 6'(pc); t.pc1 = 6'(pc1);
        t.valid = v; t.halted = h;
        return t;
    endfunction

    task automatic check(input string name, input vec_t e);
        n_vec++;
        if (imem_addr !== e.addr || if_id_instr !== e.instr || if_id_pc !== e.pc ||
            if_id_pc_plus1 !== e.pc1 || if_id_valid !== e.valid || halted !== e.halted) begin
            n_err++;
            $display("FAIL %s: got addr=%0d instr=%h pc=%0d pc1=%0d v=%b h=%b, want addr=%0d instr=%h pc=%0d pc1=%0d v=%b h=%b",
                     name, imem_addr, if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, halted,
                     e.addr, e.instr, e.pc, e.pc1, e.valid, e.halted);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; stall = v.stall; redirect_valid = v.rv; redirect_target = v.rt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(name, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        for (int k = 0; k < 64; k++) mem[k] = 32'h0000_1000 + k;

        // reset held
        tbl.push_back(mk(0,0,0,0,  0, 32'h0,     0, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0,  0, 32'h0,     0, 0, 0, 0));
        // sequential run
        tbl.push_back(mk(1,0,0,0,  1, 32'h1000,  0, 1, 1, 0));
        tbl.push_back(mk(1,0,0,0,  2, 32'h1001,  1, 2, 1, 0));
        tbl.push_back(mk(1,0,0,0,  3, 32'h1002,  2, 3, 1, 0));
        tbl.push_back(mk(1,0,0,0,  4, 32'h1003,  3, 4, 1, 0));
        tbl.push_back(mk(1,0,0,0,  5, 32'h1004,  4, 5, 1, 0));
        // stall 3 cycles at pc=5
        tbl.push_back(mk(1,1,0,0,  5, 32'h1004,  4, 5, 1, 0));
        tbl.push_back(mk(1,1,0,0,  5, 32'h1004,  4, 5, 1, 0));
        tbl.push_back(mk(1,1,0,0,  5, 32'h1004,  4, 5, 1, 0));
        tbl.push_back(mk(1,0,0,0,  6, 32'h1005,  5, 6, 1, 0));
        tbl.push_back(mk(1,0,0,0,  7, 32'h1006,  6, 7, 1, 0));
        tbl.push_back(mk(1,0,0,0,  8, 32'h1007,  7, 8, 1, 0));
        tbl.push_back(mk(1,0,0,0,  9, 32'h1008,  8, 9, 1, 0));
        tbl.push_back(mk(1,0,0,0, 10, 32'h1009,  9,10, 1, 0));
        // redirect with stall at pc=10
        tbl.push_back(mk(1,1,1,40,40, 32'h0,     9,10, 0, 0));
        tbl.push_back(mk(1,0,0,0, 41, 32'h1028, 40,41, 1, 0));
        // back-to-back redirects, then wrap 62,63,0
        tbl.push_back(mk(1,0,1,50,50, 32'h0,    40,41, 0, 0));
        tbl.push_back(mk(1,0,1,62,62, 32'h0,    40,41, 0, 0));
        tbl.push_back(mk(1,0,0,0, 63, 32'h103E, 62,63, 1, 0));
        tbl.push_back(mk(1,0,0,0,  0, 32'h103F, 63, 0, 1, 0));
        tbl.push_back(mk(1,0,0,0,  1, 32'h1000,  0, 1, 1, 0));

        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

        // HALT at address 7
        mem[7] = 32'hFC00_0000;
        apply("halt_redir", mk(1,0,1,7, 7, 32'h0,        0, 1, 0, 0));
        apply("halt_cap",   mk(1,0,0,0, 7, 32'hFC00_0000, 7, 8, 1, 1));
        apply("halt_stall", mk(1,1,0,0, 7, 32'hFC00_0000, 7, 8, 1, 1));
        apply("halt_idle0", mk(1,0,0,0, 7, 32'h0,        7, 8, 0, 1));
        apply("halt_idle1", mk(1,0,0,0, 7, 32'h0,        7, 8, 0, 1));
        apply("halt_exit",  mk(1,0,1,20,20, 32'h0,       7, 8, 0, 0));
        for (int k = 0; k < 10; k++)
            apply($sformatf("resume%0d", k),
                  mk(1,0,0,0, 21+k, 32'h0000_1000 + 20 + k, 20+k, 21+k, 1, 0));

        // async reset between edges at pc=30
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        e = mk(0,0,0,0, 0, 32'h0, 0, 0, 0, 0);
        check("async_rst", e);
        apply("rst_hold",  mk(0,0,0,0, 0, 32'h0,    0, 0, 0, 0));
        apply("rst_first", mk(1,0,0,0, 1, 32'h1000, 0, 1, 1, 0));

        // reset while halted clears halted immediately
        apply("h2_redir",  mk(1,0,1,7, 7, 32'h0,        0, 1, 0, 0));
        apply("h2_cap",    mk(1,0,0,0, 7, 32'hFC00_0000, 7, 8, 1, 1));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_halt", e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
